prog_loader: RTL and testbench

//  Hardware boot loader for the single-cycle RISC-V TOP: after reset it holds the core in reset
//  and accepts a byte stream of framed load records. It writes the decoded words into N_MEM

---
 rtl/prog_loader_if.sv | 24 ++
 rtl/prog_loader.sv | 179 +++++++++++++++++
 tb/tb_prog_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream input and memory write port of the boot loader.
// slave = loader side, master = stream source / memory side.
interface prog_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int N_MEM  = 2
);
  logic [7:0]        IN_DATA;
  logic              IN_VALID;
  logic              IN_READY;
  logic [N_MEM-1:0]  MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [DATA_W-1:0] MEM_DATAIN;

  modport slave (
    input  IN_DATA, IN_VALID,
    output IN_READY, MEM_WE, MEM_ADDRESS, MEM_DATAIN
  );

  modport master (
    output IN_DATA, IN_VALID,
    input  IN_READY, MEM_WE, MEM_ADDRESS, MEM_DATAIN
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: decodes framed load records into memory writes, holds the core in reset until GO.
// Optional per-record XOR checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
//
// state | meaning
// TGT   | waiting for target id byte (0xFF = GO)
// CNT0  | waiting for word count low byte
// CNT1  | waiting for word count high byte
// PAY   | assembling payload words, one strobe per completed word
// CHK   | waiting for checksum byte (checksum build only)
// RUN   | load complete, core released
// ERR   | framing/checksum error, core held in reset
module prog_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int N_MEM  = 2,
  parameter int CNT_W  = 16
) (
  input  logic          CLK,
  input  logic          RESET_N,
  prog_loader_if.slave  bus,
  output logic          CORE_RESET_N,
  output logic          LOAD_DONE,
  output logic          LOAD_ERR
);
  localparam int     BPW    = DATA_W / 8;
  localparam int     BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int     TGT_W  = (N_MEM > 1) ? $clog2(N_MEM) : 1;
  localparam longint MAX_N  = longint'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_TGT, S_CNT0, S_CNT1, S_PAY, S_CHK, S_RUN, S_ERR
  } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHK;
`else
  localparam state_t S_END = S_TGT;
`endif

  state_t            state_q;
  logic              rdy_q;
  logic [TGT_W-1:0]  tgt_q;
  logic [7:0]        cnt_lo_q;
  logic [CNT_W-1:0]  rem_q;
  logic [ADDR_W-1:0] widx_q;
  logic [BIDX_W-1:0] bidx_q;
  logic [DATA_W-1:0] sh_q;
  logic [N_MEM-1:0]  we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              core_q;
  logic              done_q;
  logic              err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q;
`endif

  logic              acc;
  logic [CNT_W-1:0]  n_word;
  logic [DATA_W+7:0] ext;
  logic [DATA_W-1:0] word;
  logic              last_byte;
  logic              tgt_ok;

  assign acc       = bus.IN_VALID & rdy_q;
  assign n_word    = CNT_W'({bus.IN_DATA, cnt_lo_q});
  // Bytes arrive LSB first, so each new byte enters at the top and the word shifts down.
  assign ext       = {bus.IN_DATA, sh_q};
  assign word      = ext[DATA_W+7:8];
  assign last_byte = (bidx_q == BIDX_W'(BPW - 1));
  assign tgt_ok    = (32'(bus.IN_DATA) < 32'(N_MEM));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_TGT;
      rdy_q    <= 1'b0;
      tgt_q    <= '0;
      cnt_lo_q <= '0;
      rem_q    <= '0;
      widx_q   <= '0;
      bidx_q   <= '0;
      sh_q     <= '0;
      we_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      core_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_q    <= '0;
`endif
    end else begin
      we_q <= '0;
      if (state_q != S_RUN && state_q != S_ERR) rdy_q <= 1'b1;
      case (state_q)
        S_TGT: if (acc) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          chk_q <= bus.IN_DATA;
`endif
          if (bus.IN_DATA == 8'hFF) begin
            state_q <= S_RUN;
            rdy_q   <= 1'b0;
            core_q  <= 1'b1;
            done_q  <= 1'b1;
          end else if (tgt_ok) begin
            tgt_q   <= TGT_W'(bus.IN_DATA);
            state_q <= S_CNT0;
          end else begin
            state_q <= S_ERR;
            rdy_q   <= 1'b0;
            err_q   <= 1'b1;
          end
        end
        S_CNT0: if (acc) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          chk_q <= chk_q ^ bus.IN_DATA;
`endif
          cnt_lo_q <= bus.IN_DATA;
          state_q  <= S_CNT1;
        end
        S_CNT1: if (acc) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          chk_q <= chk_q ^ bus.IN_DATA;
`endif
          if (n_word == '0) begin
            state_q <= S_END;
          end else if (longint'(n_word) > MAX_N) begin
            state_q <= S_ERR;
            rdy_q   <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            rem_q   <= n_word;
            widx_q  <= '0;
            bidx_q  <= '0;
            state_q <= S_PAY;
          end
        end
        S_PAY: if (acc) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          chk_q <= chk_q ^ bus.IN_DATA;
`endif
          sh_q <= word;
          if (last_byte) begin
            bidx_q <= '0;
            we_q   <= N_MEM'(1) << tgt_q;
            addr_q <= widx_q;
            data_q <= word;
            widx_q <= widx_q + 1'b1;
            rem_q  <= rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) state_q <= S_END;
          end else begin
            bidx_q <= bidx_q + 1'b1;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        // Words already strobed stay written even if the checksum then fails.
        S_CHK: if (acc) begin
          if (bus.IN_DATA == chk_q) begin
            state_q <= S_TGT;
          end else begin
            state_q <= S_ERR;
            rdy_q   <= 1'b0;
            err_q   <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.IN_READY    = rdy_q;
  assign bus.MEM_WE      = we_q;
  assign bus.MEM_ADDRESS = addr_q;
  assign bus.MEM_DATAIN  = data_q;
  assign CORE_RESET_N    = core_q;
  assign LOAD_DONE       = done_q;
  assign LOAD_ERR        = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed tables, corner sequences and random record streams
// compared against a record-parsing reference model.
`timescale 1ns/1ps
module tb_prog_loader;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int N_MEM  = 2;
  localparam int CNT_W  = 16;
  localparam int BPW    = DATA_W / 8;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic CORE_RESET_N, LOAD_DONE, LOAD_ERR;

  prog_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_MEM(N_MEM)) bus ();

  prog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_MEM(N_MEM), .CNT_W(CNT_W)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .bus          (bus),
    .CORE_RESET_N (CORE_RESET_N),
    .LOAD_DONE    (LOAD_DONE),
    .LOAD_ERR     (LOAD_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          mem;
    int          addr;
    logic [31:0] data;
    int          cyc;
    int          pos;
  } wr_t;

  typedef struct {
    string name;
    int    tgt;
    int    n;
    int    dmode;
    bit    bad_chk;
    bit    go;
    bit    exp_err;
    bit    exp_done;
    int    exp_nwr;
  } vec_t;

  wr_t          got[$];
  wr_t          exp_wr[$];
  byte unsigned stim[$];
  logic [31:0]  words[$];
  int           acc_cyc[$];
  int           ncyc = 0;
  int           checks = 0;
  int           errors = 0;
  bit           exp_err, exp_done;
  int           exp_cons;
  vec_t         vecs[7];

  // Strobe monitor, sampled on the falling edge.
  initial forever begin
    wr_t w;
    @(negedge CLK);
    ncyc++;
    if (bus.MEM_WE !== '0) begin
      w.mem = -1;
      for (int k = 0; k < N_MEM; k++)
        if (bus.MEM_WE === (N_MEM'(1) << k)) w.mem = k;
      w.addr = int'(bus.MEM_ADDRESS);
      w.data = bus.MEM_DATAIN;
      w.cyc  = ncyc;
      w.pos  = 0;
      got.push_back(w);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge CLK);
      bus.IN_VALID = 1'b0;
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < BPW; k++) stim.push_back(w[8*k +: 8]);
  endtask

  // dmode: 0 random words, 1 word = index, 2 words from the 'words' queue
  task automatic add_record(input int tgt, input int n, input int dmode, input bit bad_chk);
    byte unsigned x;
    int s0;
    s0 = stim.size();
    stim.push_back(8'(tgt));
    stim.push_back(8'(n));
    stim.push_back(8'(n >> 8));
    for (int w = 0; w < n; w++)
      push_word(dmode == 1 ? 32'(w) : (dmode == 2 ? words[w] : $urandom()));
    if (CHK_ON) begin
      x = 8'h00;
      for (int k = s0; k < stim.size(); k++) x = x ^ stim[k];
      stim.push_back(bad_chk ? (x ^ 8'h01) : x);
    end
  endtask

  // Parses the stream by the record rules and lists the expected writes.
  task automatic model_run();
    int i;
    int n, tgt;
    logic [31:0] wd;
    byte unsigned x;
    bit stop;
    i = 0;
    stop = 1'b0;
    exp_wr.delete();
    exp_err = 1'b0;
    exp_done = 1'b0;
    while (!stop && i < stim.size()) begin
      tgt = int'(stim[i]);
      i++;
      if (tgt == 255) begin
        exp_done = 1'b1; stop = 1'b1;
      end else if (tgt >= N_MEM) begin
        exp_err = 1'b1; stop = 1'b1;
      end else if (i + 2 > stim.size()) begin
        i = stim.size(); stop = 1'b1;
      end else begin
        n = int'(stim[i]) + 256 * int'(stim[i+1]);
        x = 8'(tgt) ^ stim[i] ^ stim[i+1];
        i += 2;
        if (n > (1 << ADDR_W)) begin
          exp_err = 1'b1; stop = 1'b1;
        end else begin
          for (int w = 0; w < n && !stop; w++) begin
            if (i + BPW > stim.size()) begin
              i = stim.size(); stop = 1'b1;
            end else begin
              wd = '0;
              for (int k = 0; k < BPW; k++) begin
                wd[8*k +: 8] = stim[i+k];
                x = x ^ stim[i+k];
              end
              exp_wr.push_back('{mem: tgt, addr: w, data: wd, cyc: 0, pos: i + BPW - 1});
              i += BPW;
            end
          end
          if (!stop && CHK_ON) begin
            if (i >= stim.size()) stop = 1'b1;
            else begin
              if (stim[i] != x) begin exp_err = 1'b1; stop = 1'b1; end
              i++;
            end
          end
        end
      end
    end
    exp_cons = i;
  endtask

  // stall < 0: one idle cycle before every byte; otherwise percent chance of 1-3 idle cycles.
  task automatic play(input int stall);
    bit ok;
    acc_cyc.delete();
    foreach (stim[j]) begin
      if (stall < 0) idle(1);
      else if (int'($urandom_range(99)) < stall) idle(int'($urandom_range(3, 1)));
      ok = 1'b0;
      for (int b = 0; b < 8 && !ok; b++) begin
        @(negedge CLK);
        bus.IN_DATA  = stim[j];
        bus.IN_VALID = 1'b1;
        if (bus.IN_READY === 1'b1) begin
          @(posedge CLK);
          acc_cyc.push_back(ncyc);
          ok = 1'b1;
        end
      end
      if (!ok) break;
    end
    @(negedge CLK);
    bus.IN_VALID = 1'b0;
  endtask

  task automatic check_stream(input string name);
    int ec;
    model_run();
    idle(4);
    check({name, " consumed"}, 64'(acc_cyc.size()), 64'(exp_cons));
    check({name, " nwrites"}, 64'(got.size()), 64'(exp_wr.size()));
    for (int k = 0; k < got.size() && k < exp_wr.size(); k++) begin
      ec = (exp_wr[k].pos < acc_cyc.size()) ? acc_cyc[exp_wr[k].pos] + 1 : -1;
      check($sformatf("%s wr%0d mem", name, k), 64'(got[k].mem), 64'(exp_wr[k].mem));
      check($sformatf("%s wr%0d addr", name, k), 64'(got[k].addr), 64'(exp_wr[k].addr));
      check($sformatf("%s wr%0d data", name, k), 64'(got[k].data), 64'(exp_wr[k].data));
      check($sformatf("%s wr%0d cycle", name, k), 64'(got[k].cyc), 64'(ec));
    end
    check({name, " load_err"}, 64'(LOAD_ERR), 64'(exp_err));
    check({name, " load_done"}, 64'(LOAD_DONE), 64'(exp_done));
    check({name, " core_reset_n"}, 64'(CORE_RESET_N), 64'(exp_done));
    check({name, " in_ready"}, 64'(bus.IN_READY), 64'(!(exp_err || exp_done)));
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " mem_we"}, 64'(bus.MEM_WE), 64'(0));
    check({name, " mem_addr"}, 64'(bus.MEM_ADDRESS), 64'(0));
    check({name, " mem_data"}, 64'(bus.MEM_DATAIN), 64'(0));
    check({name, " core_reset_n"}, 64'(CORE_RESET_N), 64'(0));
    check({name, " load_done"}, 64'(LOAD_DONE), 64'(0));
    check({name, " load_err"}, 64'(LOAD_ERR), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    bus.IN_VALID = 1'b0;
    bus.IN_DATA = 8'h00;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    got.delete();
    stim.delete();
    acc_cyc.delete();
  endtask

  initial begin
    bus.IN_VALID = 1'b0;
    bus.IN_DATA  = 8'h00;
    vecs[0] = '{"bad_tgt",   5,    0,    0, 1'b0, 1'b0, 1'b1,    1'b0,    0};
    vecs[1] = '{"n_over",    0,    'h401, 0, 1'b0, 1'b0, 1'b1,   1'b0,    0};
    vecs[2] = '{"n_zero",    0,    0,    0, 1'b0, 1'b1, 1'b0,    1'b1,    0};
    vecs[3] = '{"n_max",     0,    1024, 1, 1'b0, 1'b1, 1'b0,    1'b1,    1024};
    vecs[4] = '{"tgt1_go",   1,    3,    0, 1'b0, 1'b1, 1'b0,    1'b1,    3};
    vecs[5] = '{"go_only",   255,  0,    0, 1'b0, 1'b0, 1'b0,    1'b1,    0};
    vecs[6] = '{"bad_chk",   0,    1,    0, 1'b1, 1'b1, CHK_ON,  !CHK_ON, 1};

    // Reset values, IN_READY low while in reset and high after.
    repeat (2) @(negedge CLK);
    check_reset_vals("rst");
    check("rst in_ready", 64'(bus.IN_READY), 64'(0));
    RESET_N = 1'b1;
    got.delete();
    repeat (2) @(negedge CLK);
    check("rst in_ready after", 64'(bus.IN_READY), 64'(1));
    check_reset_vals("idle");

    // T1: reset mid-payload, partial word must vanish without a strobe.
    stim.delete();
    stim = '{8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
    play(0);
    #2 RESET_N = 1'b0;
    #1 check_reset_vals("t1 async");
    check("t1 in_ready", 64'(bus.IN_READY), 64'(0));
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    stim.delete();
    words = '{32'h44332211};
    add_record(0, 1, 2, 1'b0);
    play(0);
    check_stream("t1");

    // T2: two-word program into target 0, then GO.
    do_reset();
    words = '{32'h00500093, 32'h00100113};
    add_record(0, 2, 2, 1'b0);
    stim.push_back(8'hFF);
    play(0);
    check_stream("t2");
    check("t2 word1 data", got.size() > 1 ? 64'(got[1].data) : 64'hx, 64'h00100113);

    // T3: target 1, valid toggled every other cycle.
    do_reset();
    words = '{32'hDEADBEEF};
    add_record(1, 1, 2, 1'b0);
    play(-1);
    check_stream("t3");

    // T6: fixed stream 00,01,00,11,22,33,44 with good then bad checksum byte.
    do_reset();
    stim = '{8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    if (CHK_ON) stim.push_back(8'h45);
    stim.push_back(8'hFF);
    play(0);
    check_stream("t6 good");
    do_reset();
    stim = '{8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    if (CHK_ON) stim.push_back(8'h46);
    play(0);
    check_stream("t6 bad");
    check("t6 bad err", 64'(LOAD_ERR), 64'(CHK_ON));

    // Table-driven single-record vectors.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      if (vecs[v].tgt == 255 || vecs[v].tgt >= N_MEM) begin
        stim.push_back(8'(vecs[v].tgt));
      end else if (vecs[v].n > (1 << ADDR_W)) begin
        stim.push_back(8'(vecs[v].tgt));
        stim.push_back(8'(vecs[v].n));
        stim.push_back(8'(vecs[v].n >> 8));
      end else begin
        add_record(vecs[v].tgt, vecs[v].n, vecs[v].dmode, vecs[v].bad_chk);
      end
      if (vecs[v].go) stim.push_back(8'hFF);
      play(0);
      check_stream(vecs[v].name);
      check({vecs[v].name, " tbl err"}, 64'(LOAD_ERR), 64'(vecs[v].exp_err));
      check({vecs[v].name, " tbl done"}, 64'(LOAD_DONE), 64'(vecs[v].exp_done));
      check({vecs[v].name, " tbl nwr"}, 64'(got.size()), 64'(vecs[v].exp_nwr));
      if (vecs[v].exp_nwr > 0)
        check({vecs[v].name, " last addr"}, got.size() > 0 ? 64'(got[$].addr) : 64'hx,
              64'(vecs[v].exp_nwr - 1));
    end

    // Random multi-record streams with random stalls.
    for (int r = 0; r < 25; r++) begin
      do_reset();
      for (int k = 0; k < int'($urandom_range(4, 1)); k++)
        add_record(int'($urandom_range(1, 0)), int'($urandom_range(6, 0)), 0,
                   $urandom_range(9, 0) == 0);
      if ($urandom_range(9, 0) == 0) stim.push_back(8'($urandom_range(254, 2)));
      else stim.push_back(8'hFF);
      play(int'($urandom_range(60, 0)));
      check_stream($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
